sample_framer: RTL and testbench

SAMPLE_FRAMER -- requirements
Module: sample_framer

---
 rtl/sample_framer.sv | 150 +++++++++++++++
 tb/tb_sample_framer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_framer.sv
// Frames a stream of ADC samples into RUNS frames of 2**FFT_DEPTH words through a
// small first-word-fall-through FIFO with sop/eop/run tagging for the FFT input.
module sample_framer #(
    parameter int SINK_WIDTH = 14,
    parameter int FFT_DEPTH  = 11,
    parameter int RUNS       = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int RUN_W     = (RUNS > 1) ? $clog2(RUNS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  sink_valid,
    input  logic [SINK_WIDTH-1:0] sink,
    input  logic                  source_ready,
    output logic                  source_valid,
    output logic [SINK_WIDTH-1:0] source_data,
    output logic                  source_sop,
    output logic                  source_eop,
    output logic [RUN_W-1:0]      source_run,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int TOTAL = RUNS * (2 ** FFT_DEPTH);
    localparam int CAP_W = $clog2(TOTAL + 1);
    localparam int DEPTH = 2 ** FIFO_DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SINK_WIDTH-1:0] r_mem [DEPTH];
    logic [FIFO_DEPTH:0]   r_wptr;
    logic [FIFO_DEPTH:0]   r_rptr;
    logic [CAP_W-1:0]      r_cap_cnt;
    logic [FFT_DEPTH-1:0]  r_out_cnt;
    logic [RUN_W-1:0]      r_run;
    logic                  r_final;
    logic                  r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_cap_done;
    logic w_start;
    logic w_last_eop;
    logic w_done;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[FIFO_DEPTH] != r_rptr[FIFO_DEPTH]) &&
                        (r_wptr[FIFO_DEPTH-1:0] == r_rptr[FIFO_DEPTH-1:0]);
    assign w_pop      = !w_empty && source_ready;
    assign w_cap_done = (r_cap_cnt == CAP_W'(TOTAL));
    // A pop in the same cycle frees the slot being overwritten, so full+pop still accepts.
    assign w_push     = (r_state == ST_CAPTURE) && sink_valid && !w_cap_done && (!w_full || w_pop);
    assign w_drop     = (r_state == ST_CAPTURE) && sink_valid && !w_cap_done && w_full && !w_pop;
    assign w_start    = (r_state == ST_IDLE) && start;
    assign w_last_eop = w_pop && source_eop && (r_run == RUN_W'(RUNS - 1));

    assign source_valid = !w_empty;
    assign source_data  = w_empty ? '0 : r_mem[r_rptr[FIFO_DEPTH-1:0]];
    assign source_sop   = !w_empty && (r_out_cnt == '0);
    assign source_eop   = !w_empty && (r_out_cnt == '1);
    assign source_run   = r_run;
    assign busy         = (r_state != ST_IDLE);
    assign done         = w_done;
    assign overflow     = r_overflow;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and the one-cycle done pulse on leaving FLUSH
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_CAPTURE;
                else       w_state_nxt = ST_IDLE;
            end
            ST_CAPTURE: begin
                if (w_cap_done) w_state_nxt = ST_FLUSH;
                else            w_state_nxt = ST_CAPTURE;
            end
            ST_FLUSH: begin
                if (r_final && w_empty) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sample storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[FIFO_DEPTH-1:0]] <= sink;
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Capture/output counters, run index, final-eop flag and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap_cnt  <= '0;
            r_out_cnt  <= '0;
            r_run      <= '0;
            r_final    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_cap_cnt  <= '0;
            r_out_cnt  <= '0;
            r_run      <= '0;
            r_final    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_cap_cnt <= r_cap_cnt + 1'b1;
            if (w_pop)  r_out_cnt <= r_out_cnt + 1'b1;
            if (w_pop && source_eop && (r_run != RUN_W'(RUNS - 1))) r_run <= r_run + 1'b1;
            if (w_last_eop) r_final <= 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer: a vector table for two full captures plus
// hand-written overflow, reset-abort and back-pressure sequences.
module tb_sample_framer;

    localparam int SW = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          sink_valid;
    logic [SW-1:0] sink;
    logic          source_ready;
    logic          source_valid;
    logic [SW-1:0] source_data;
    logic          source_sop;
    logic          source_eop;
    logic [0:0]    source_run;
    logic          busy;
    logic          done;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    typedef struct {
        logic          start_before;
        logic [SW-1:0] sink;
        logic [SW-1:0] exp_data;
        logic          exp_sop;
        logic          exp_eop;
        logic [0:0]    exp_run;
    } vec_t;

    vec_t vecs [32];

    sample_framer #(
        .SINK_WIDTH(14),
        .FFT_DEPTH (3),
        .RUNS      (2),
        .FIFO_DEPTH(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .sink_valid  (sink_valid),
        .sink        (sink),
        .source_ready(source_ready),
        .source_valid(source_valid),
        .source_data (source_data),
        .source_sop  (source_sop),
        .source_eop  (source_eop),
        .source_run  (source_run),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("idle_reached", n, {31'd0, busy}, 32'd0);
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].start_before) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            sink       = vecs[i].sink;
            sink_valid = 1'b1;
            tick();
            sink_valid = 1'b0;
            check("row_valid", i, {31'd0, source_valid}, 32'd1);
            check("row_data",  i, {18'd0, source_data},  {18'd0, vecs[i].exp_data});
            check("row_sop",   i, {31'd0, source_sop},   {31'd0, vecs[i].exp_sop});
            check("row_eop",   i, {31'd0, source_eop},   {31'd0, vecs[i].exp_eop});
            check("row_run",   i, {31'd0, source_run},   {31'd0, vecs[i].exp_run});
            tick();
            tick();
        end
    endtask

    task automatic strobe(input int value);
        sink       = value[SW-1:0];
        sink_valid = 1'b1;
        tick();
        sink_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin : main
        int d0;
        int q[$];
        int val, cap, outn, cyc;
        bit rdy, pop, push, prev_hold, exp_ovf;
        logic [SW-1:0] prev_data;

        // Rows 0-15: capture of 1..16; rows 16-31: capture starting with the
        // two extreme codes, with a stray start after five samples (row 21).
        for (int i = 0; i < 32; i++) begin
            int k;
            k = i % 16;
            vecs[i].start_before = (k == 0) || (i == 21);
            vecs[i].sink         = SW'(k + 1);
            if (i == 16) vecs[i].sink = 14'h2000;
            if (i == 17) vecs[i].sink = 14'h1FFF;
            vecs[i].exp_data     = vecs[i].sink;
            vecs[i].exp_sop      = (k % 8 == 0);
            vecs[i].exp_eop      = (k % 8 == 7);
            vecs[i].exp_run      = 1'(k / 8);
        end

        reset_n      = 1'b0;
        start        = 1'b0;
        sink_valid   = 1'b0;
        sink         = '0;
        source_ready = 1'b1;
        #2;
        check("rst_valid", 0, {31'd0, source_valid}, 32'd0);
        check("rst_data",  0, {18'd0, source_data},  32'd0);
        check("rst_sop",   0, {31'd0, source_sop},   32'd0);
        check("rst_eop",   0, {31'd0, source_eop},   32'd0);
        check("rst_run",   0, {31'd0, source_run},   32'd0);
        check("rst_busy",  0, {31'd0, busy},         32'd0);
        check("rst_done",  0, {31'd0, done},         32'd0);
        check("rst_ovf",   0, {31'd0, overflow},     32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_rst_busy", 0, {31'd0, busy}, 32'd0);

        // Extreme codes offered while idle must not be captured
        sink       = 14'h2000;
        sink_valid = 1'b1;
        tick();
        sink       = 14'h1FFF;
        tick();
        sink_valid = 1'b0;
        tick();
        check("idle_ignore_valid", 0, {31'd0, source_valid}, 32'd0);
        check("idle_ignore_busy",  0, {31'd0, busy},         32'd0);

        d0 = done_cnt;
        apply_rows(0, 15);
        wait_idle();
        check("cap1_done_pulses", 0, done_cnt - d0, 32'd1);
        check("cap1_ovf",         0, {31'd0, overflow},     32'd0);
        check("cap1_valid",       0, {31'd0, source_valid}, 32'd0);

        d0 = done_cnt;
        apply_rows(16, 31);
        wait_idle();
        check("cap2_done_pulses", 0, done_cnt - d0, 32'd1);
        check("cap2_ovf",         0, {31'd0, overflow}, 32'd0);

        // No back-pressure relief: four samples fill the FIFO, the rest drop
        source_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            strobe(k);
            if (k >= 1) check("stall_data", k, {18'd0, source_data}, 32'd1);
        end
        check("stall_ovf",   0, {31'd0, overflow},     32'd1);
        check("stall_busy",  0, {31'd0, busy},         32'd1);
        check("stall_valid", 0, {31'd0, source_valid}, 32'd1);
        check("stall_sop",   0, {31'd0, source_sop},   32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 0, {31'd0, source_valid}, 32'd0);
        check("async_rst_busy",  0, {31'd0, busy},         32'd0);
        check("async_rst_ovf",   0, {31'd0, overflow},     32'd0);
        check("async_rst_data",  0, {18'd0, source_data},  32'd0);
        tick();
        reset_n      = 1'b1;
        source_ready = 1'b1;
        tick();

        // Abort after 6 written / 2 read, then a fresh capture
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        strobe(1);
        strobe(2);
        source_ready = 1'b0;
        for (int k = 3; k <= 6; k++) strobe(k);
        check("abort_pre_valid", 0, {31'd0, source_valid}, 32'd1);
        check("abort_pre_data",  0, {18'd0, source_data},  32'd3);
        reset_n = 1'b0;
        tick();
        check("abort_valid", 0, {31'd0, source_valid}, 32'd0);
        check("abort_busy",  0, {31'd0, busy},         32'd0);
        reset_n = 1'b1;
        repeat (5) tick();
        check("abort_no_done", 0, done_cnt - d0, 32'd0);
        check("abort_idle",    0, {31'd0, busy}, 32'd0);
        source_ready = 1'b1;
        apply_rows(0, 15);
        wait_idle();
        check("recap_done_pulses", 0, done_cnt - d0, 32'd1);

        // Back-to-back writes with ready toggling, against a 4-entry queue model
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        val = 1; cap = 0; outn = 0; cyc = 0;
        rdy = 1'b1; prev_hold = 1'b0; exp_ovf = 1'b0; prev_data = '0;
        while (outn < 16 && cyc < 200) begin
            source_ready = rdy;
            if (cap < 16) begin
                sink_valid = 1'b1;
                sink       = val[SW-1:0];
            end else begin
                sink_valid = 1'b0;
            end
            #1;
            check("bp_valid", cyc, {31'd0, source_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) begin
                check("bp_data", cyc, {18'd0, source_data}, q[0]);
                check("bp_sop",  cyc, {31'd0, source_sop},  {31'd0, (outn % 8) == 0});
                check("bp_eop",  cyc, {31'd0, source_eop},  {31'd0, (outn % 8) == 7});
                check("bp_run",  cyc, {31'd0, source_run},  outn / 8);
            end
            if (prev_hold) check("bp_hold", cyc, {18'd0, source_data}, {18'd0, prev_data});
            pop  = (q.size() != 0) && rdy;
            push = sink_valid && ((q.size() < 4) || pop);
            if (sink_valid && !push) exp_ovf = 1'b1;
            prev_hold = (q.size() != 0) && !rdy;
            prev_data = source_data;
            tick();
            if (pop) begin
                void'(q.pop_front());
                outn++;
            end
            if (push) begin
                q.push_back(val);
                cap++;
            end
            if (sink_valid) val++;
            rdy = !rdy;
            cyc++;
        end
        sink_valid   = 1'b0;
        source_ready = 1'b1;
        check("bp_words", 0, outn, 32'd16);
        check("bp_ovf",   0, {31'd0, overflow}, {31'd0, exp_ovf});
        wait_idle();
        check("bp_done_pulses", 0, done_cnt - d0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
